// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multi-cycle MIPS-subset core (lw, sw, R-type, beq, j).
// Latency: lw 5, sw 4, R-type 4, beq 3, j 3 cycles; +1 per mem_ready-low cycle in FETCH/MEMRD/MEMWR.
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready; all other states advance every clock.
module multicycle_ctrl_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    state_t cur;

    // Raw write enables before the reset override
    logic pc_write_raw;
    logic mem_write_raw;
    logic ir_write_raw;
    logic reg_write_raw;

    // State register, sticky illegal flag and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur        <= S_FETCH;
            illegal_op <= 1'b0;
            retired    <= '0;
        end else begin
            if (instr_done) begin
                retired <= retired + CNT_W'(1);
            end
            case (cur)
                S_FETCH:  if (mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    if (opcode == OP_LW || opcode == OP_SW) begin
                        cur <= S_MEMADR;
                    end else if (opcode == OP_RTYPE) begin
                        cur <= S_EXEC;
                    end else if (opcode == OP_BEQ) begin
                        cur <= S_BRANCH;
                    end else if (opcode == OP_J) begin
                        cur <= S_JUMP;
                    end else begin
                        // Undecodable: drop the instruction without retiring it
                        cur        <= S_FETCH;
                        illegal_op <= 1'b1;
                    end
                end
                S_MEMADR: begin
                    if (opcode == OP_LW)      cur <= S_MEMRD;
                    else if (opcode == OP_SW) cur <= S_MEMWR;
                    else                      cur <= S_FETCH;
                end
                S_MEMRD:  if (mem_ready) cur <= S_MEMWB;
                S_MEMWB:  cur <= S_FETCH;
                S_MEMWR:  if (mem_ready) cur <= S_FETCH;
                S_EXEC:   cur <= S_ALUWB;
                S_ALUWB:  cur <= S_FETCH;
                S_BRANCH: cur <= S_FETCH;
                S_JUMP:   cur <= S_FETCH;
                default:  cur <= S_FETCH;
            endcase
        end
    end

    // Moore decode of the datapath controls from the current state
    always_comb begin
        pc_write_raw  = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        case (cur)
            S_FETCH: begin
                mem_read     = 1'b1;
                alu_src_b    = 2'b01;
                // IR and PC only load once the fetch actually completes
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
                instr_done    = 1'b1;
            end
            S_MEMWR: begin
                iord          = 1'b1;
                mem_write_raw = 1'b1;
                instr_done    = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
                instr_done    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_op       = 2'b01;
                pc_source    = 2'b01;
                pc_write_raw = zero;
                instr_done   = 1'b1;
            end
            S_JUMP: begin
                pc_write_raw = 1'b1;
                pc_source    = 2'b10;
                instr_done   = 1'b1;
            end
            default: begin
                pc_write_raw = 1'b0;
            end
        endcase
    end

    // No architectural write may fire while reset is held
    assign pc_write  = pc_write_raw  & ~reset;
    assign mem_write = mem_write_raw & ~reset;
    assign ir_write  = ir_write_raw  & ~reset;
    assign reg_write = reg_write_raw & ~reset;
    assign state     = cur;

endmodule
